// File: rtl/sha256_host_loader_pkg.sv
// Shared definitions for the SHA-256 host loader:
// core register map, start value and FSM states.
package sha256_host_loader_pkg;

  localparam logic [6:0] ADDR_WORD_HI = 7'd63;
  localparam logic [6:0] ADDR_WHO     = 7'd64;
  localparam logic [6:0] ADDR_STATUS  = 7'd65;
  localparam logic [6:0] ADDR_DIG_HI  = 7'd101;
  localparam logic [7:0] START_VAL    = 8'h01;

  localparam logic [5:0] MSG_LAST = 6'd63;
  localparam logic [5:0] DIG_LAST = 6'd31;

  typedef enum logic [2:0] {
    ST_PROBE,
    ST_IDLE,
    ST_CLR,
    ST_LOAD,
    ST_START,
    ST_WAIT,
    ST_READ,
    ST_ERR
  } state_e;

endpackage

// File: rtl/sha256_host_loader_if.sv
// Byte streams in/out plus the byte-wide core register port,
// seen from the loader (master) and its environment (slave).
interface sha256_host_loader_if;

  logic [7:0] i_s_data;
  logic       i_s_valid;
  logic       o_s_ready;
  logic [7:0] o_m_data;
  logic       o_m_valid;
  logic       o_m_last;
  logic       i_m_ready;
  logic [6:0] o_core_addr;
  logic [7:0] o_core_data;
  logic       o_core_we;
  logic       o_core_rst_n;
  logic [7:0] i_core_data;
  logic       i_core_irq;

  modport master (
    input  i_s_data, i_s_valid,
    output o_s_ready,
    output o_m_data, o_m_valid, o_m_last,
    input  i_m_ready,
    output o_core_addr, o_core_data, o_core_we, o_core_rst_n,
    input  i_core_data, i_core_irq
  );

  modport slave (
    output i_s_data, i_s_valid,
    input  o_s_ready,
    input  o_m_data, o_m_valid, o_m_last,
    output i_m_ready,
    input  o_core_addr, o_core_data, o_core_we, o_core_rst_n,
    output i_core_data, i_core_irq
  );

endinterface

// File: rtl/sha256_host_loader.sv
// Loads one padded block into the SHA-256 core, starts it,
// waits for completion and streams the 32-byte digest out.
module sha256_host_loader
  import sha256_host_loader_pkg::*;
#(
  parameter logic [7:0] EXPECT_ID = 8'd1,
  parameter bit         CHECK_ID  = 1'b1,
  parameter int         TIMEOUT_W = 10
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  sha256_host_loader_if.master        bus,
  output logic                        o_busy,
  output logic                        o_err
);

  localparam state_e RST_STATE = CHECK_ID ? ST_PROBE : ST_IDLE;

  state_e                 state_q, state_d;
  logic [5:0]             cnt_q, cnt_d;
  logic [TIMEOUT_W-1:0]   timer_q, timer_d, timer_inc;
  logic                   core_rst_n_q, core_rst_n_d;

  logic [6:0] addr;
  logic [7:0] wdata;
  logic       we;
  logic       s_ready;
  logic       m_valid;
  logic       m_last;

  assign timer_inc = timer_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    timer_d = timer_q;
    addr    = ADDR_WHO;
    wdata   = 8'h00;
    we      = 1'b0;
    s_ready = 1'b0;
    m_valid = 1'b0;
    m_last  = 1'b0;
    unique case (state_q)
      ST_PROBE: begin
        state_d = (bus.i_core_data == EXPECT_ID) ? ST_IDLE : ST_ERR;
      end
      ST_IDLE: begin
        cnt_d = '0;
        if (bus.i_s_valid) state_d = ST_CLR;
      end
      ST_CLR: begin
        cnt_d   = '0;
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        s_ready = 1'b1;
        we      = bus.i_s_valid;
        addr    = ADDR_WORD_HI - {1'b0, cnt_q};
        wdata   = bus.i_s_data;
        if (bus.i_s_valid) begin
          if (cnt_q == MSG_LAST) begin
            cnt_d   = '0;
            state_d = ST_START;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end
      ST_START: begin
        we      = 1'b1;
        addr    = ADDR_STATUS;
        wdata   = START_VAL;
        timer_d = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        addr    = ADDR_STATUS;
        timer_d = timer_inc;
        // completion beats a timeout landing on the same cycle
        if (bus.i_core_irq) begin
          cnt_d   = '0;
          state_d = ST_READ;
        end else if (&timer_inc) begin
          state_d = ST_ERR;
        end
      end
      ST_READ: begin
        addr    = ADDR_DIG_HI - {1'b0, cnt_q};
        m_valid = 1'b1;
        m_last  = (cnt_q == DIG_LAST);
        if (bus.i_m_ready) begin
          if (m_last) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end
      ST_ERR: begin
        state_d = ST_ERR;
      end
    endcase
    // one-cycle core reset pulse restores the initial hash per block
    core_rst_n_d = (state_d != ST_CLR);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= RST_STATE;
      cnt_q        <= '0;
      timer_q      <= '0;
      core_rst_n_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      timer_q      <= timer_d;
      core_rst_n_q <= core_rst_n_d;
    end
  end

  assign bus.o_core_addr  = addr;
  assign bus.o_core_data  = wdata;
  assign bus.o_core_we    = we;
  assign bus.o_core_rst_n = core_rst_n_q;
  assign bus.o_s_ready    = s_ready;
  assign bus.o_m_valid    = m_valid;
  assign bus.o_m_last     = m_last;
  assign bus.o_m_data     = bus.i_core_data;

  assign o_busy = (state_q != ST_IDLE) && (state_q != ST_ERR);
  assign o_err  = (state_q == ST_ERR);

endmodule
